// File: rtl/id_decode_stage.sv
// ---------------------------------------------------------------------------
// id_decode_stage
//
// RV32I decode pipeline stage. One fetched instruction is decoded
// combinationally and captured into a single output register. That register
// holds the ALU control word, the immediate, the register indices and the
// datapath/memory control bits for the execute stage. Both sides use a
// valid/ready handshake. A flush input kills the held bundle and drops any
// instruction offered in the same cycle.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  fetch-side handshake (in_ready is combinational)
//   instr, pc          instruction word and its address
//   flush              kill the held bundle and the instruction offered now
//   out_valid/out_ready execute-side handshake
//   aluc               6-bit ALU control word
//   imm                sign-extended immediate (zero-extended shamt for shifts)
//   rs1, rs2, rd       register indices, 0 when the field is unused
//   a_sel, b_sel       operand A: 0=rs1 1=pc; operand B: 0=rs2 1=imm
//   reg_we             writeback enable, never set when rd==0
//   mem_rd, mem_wr     load / store
//   funct3_o           raw funct3 for the LSU and branch unit
//   branch, jump       conditional branch / JAL-JALR
//   illegal            unsupported encoding
// ---------------------------------------------------------------------------
module id_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      aluc,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            a_sel,
  output logic            b_sel,
  output logic            reg_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      funct3_o,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU control words: [2:0] unit select, [3] variant, [4] arithmetic shift
  localparam logic [5:0] ALU_ADD  = 6'h00;
  localparam logic [5:0] ALU_SUB  = 6'h08;
  localparam logic [5:0] ALU_AND  = 6'h02;
  localparam logic [5:0] ALU_OR   = 6'h0A;
  localparam logic [5:0] ALU_SLT  = 6'h03;
  localparam logic [5:0] ALU_SLTU = 6'h0B;
  localparam logic [5:0] ALU_XOR  = 6'h04;
  localparam logic [5:0] ALU_LUI  = 6'h0C;
  localparam logic [5:0] ALU_SLL  = 6'h05;
  localparam logic [5:0] ALU_SRL  = 6'h0D;
  localparam logic [5:0] ALU_SRA  = 6'h1D;

  // Instruction fields
  logic [6:0] f_opcode;
  logic [4:0] f_rd;
  logic [2:0] f_funct3;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [6:0] f_funct7;
  logic       f7_zero;
  logic       f7_alt;

  assign f_opcode = instr[6:0];
  assign f_rd     = instr[11:7];
  assign f_funct3 = instr[14:12];
  assign f_rs1    = instr[19:15];
  assign f_rs2    = instr[24:20];
  assign f_funct7 = instr[31:25];
  assign f7_zero  = (f_funct7 == 7'h00);
  assign f7_alt   = (f_funct7 == 7'h20);

  // Immediate formats
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sh;

  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], {(XLEN-20){1'b0}}};
  assign imm_j  = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

  // The stage carries no pc field downstream: the execute stage keeps its own
  // copy alongside the bundle, so pc is only part of the fetch-side interface.
  logic unused_pc;
  assign unused_pc = ^pc;

  // Handshake
  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Decoded bundle for the instruction currently offered by fetch
  logic [5:0]      d_aluc;
  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [4:0]      d_rd;
  logic            d_a_sel;
  logic            d_b_sel;
  logic            d_we;
  logic            d_mem_rd;
  logic            d_mem_wr;
  logic            d_branch;
  logic            d_jump;
  logic            d_illegal;

  // Main decoder. Each opcode fills in only the fields it uses; everything
  // else stays at zero. An illegal encoding is collapsed to an all-zero
  // bundle with only the illegal flag set, so nothing downstream acts on it.
  always_comb begin
    d_aluc    = ALU_ADD;
    d_imm     = '0;
    d_rs1     = '0;
    d_rs2     = '0;
    d_rd      = '0;
    d_a_sel   = 1'b0;
    d_b_sel   = 1'b0;
    d_we      = 1'b0;
    d_mem_rd  = 1'b0;
    d_mem_wr  = 1'b0;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_illegal = 1'b0;

    case (f_opcode)
      OPC_LUI: begin
        d_aluc  = ALU_LUI;
        d_imm   = imm_u;
        d_rd    = f_rd;
        d_b_sel = 1'b1;
        d_we    = 1'b1;
      end

      OPC_AUIPC: begin
        d_imm   = imm_u;
        d_rd    = f_rd;
        d_a_sel = 1'b1;
        d_b_sel = 1'b1;
        d_we    = 1'b1;
      end

      // The ALU forms the jump target (pc+imm / rs1+imm); the link value
      // is produced beside the ALU from pc.
      OPC_JAL: begin
        d_imm   = imm_j;
        d_rd    = f_rd;
        d_a_sel = 1'b1;
        d_b_sel = 1'b1;
        d_we    = 1'b1;
        d_jump  = 1'b1;
      end

      OPC_JALR: begin
        d_imm   = imm_i;
        d_rs1   = f_rs1;
        d_rd    = f_rd;
        d_b_sel = 1'b1;
        d_we    = 1'b1;
        d_jump  = 1'b1;
      end

      // Branch compare runs in the ALU: equality through the subtractor's
      // zero flag, ordering through the set-less-than unit.
      OPC_BRANCH: begin
        d_imm    = imm_b;
        d_rs1    = f_rs1;
        d_rs2    = f_rs2;
        d_branch = 1'b1;
        case (f_funct3)
          3'b000, 3'b001: d_aluc    = ALU_SUB;
          3'b100, 3'b101: d_aluc    = ALU_SLT;
          3'b110, 3'b111: d_aluc    = ALU_SLTU;
          default:        d_illegal = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        d_imm    = imm_i;
        d_rs1    = f_rs1;
        d_rd     = f_rd;
        d_b_sel  = 1'b1;
        d_we     = 1'b1;
        d_mem_rd = 1'b1;
        case (f_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: d_illegal = 1'b0;
          default:                                d_illegal = 1'b1;
        endcase
      end

      OPC_STORE: begin
        d_imm    = imm_s;
        d_rs1    = f_rs1;
        d_rs2    = f_rs2;
        d_b_sel  = 1'b1;
        d_mem_wr = 1'b1;
        case (f_funct3)
          3'b000, 3'b001, 3'b010: d_illegal = 1'b0;
          default:                d_illegal = 1'b1;
        endcase
      end

      // Immediate shifts reuse the upper immediate bits as funct7, so the
      // immediate becomes the bare shamt and funct7 is checked for legality.
      OPC_OPIMM: begin
        d_imm   = imm_i;
        d_rs1   = f_rs1;
        d_rd    = f_rd;
        d_b_sel = 1'b1;
        d_we    = 1'b1;
        case (f_funct3)
          3'b000: d_aluc = ALU_ADD;
          3'b010: d_aluc = ALU_SLT;
          3'b011: d_aluc = ALU_SLTU;
          3'b100: d_aluc = ALU_XOR;
          3'b110: d_aluc = ALU_OR;
          3'b111: d_aluc = ALU_AND;
          3'b001: begin
            d_imm = imm_sh;
            if (f7_zero) d_aluc    = ALU_SLL;
            else         d_illegal = 1'b1;
          end
          default: begin
            d_imm = imm_sh;
            if (f7_zero)     d_aluc    = ALU_SRL;
            else if (f7_alt) d_aluc    = ALU_SRA;
            else             d_illegal = 1'b1;
          end
        endcase
      end

      // Register-register: only ADD/SUB and SRL/SRA accept funct7=0x20.
      OPC_OP: begin
        d_rs1 = f_rs1;
        d_rs2 = f_rs2;
        d_rd  = f_rd;
        d_we  = 1'b1;
        case (f_funct3)
          3'b000: begin
            if (f7_zero)     d_aluc    = ALU_ADD;
            else if (f7_alt) d_aluc    = ALU_SUB;
            else             d_illegal = 1'b1;
          end
          3'b101: begin
            if (f7_zero)     d_aluc    = ALU_SRL;
            else if (f7_alt) d_aluc    = ALU_SRA;
            else             d_illegal = 1'b1;
          end
          default: begin
            if (!f7_zero) begin
              d_illegal = 1'b1;
            end else begin
              case (f_funct3)
                3'b001:  d_aluc = ALU_SLL;
                3'b010:  d_aluc = ALU_SLT;
                3'b011:  d_aluc = ALU_SLTU;
                3'b100:  d_aluc = ALU_XOR;
                3'b110:  d_aluc = ALU_OR;
                default: d_aluc = ALU_AND;
              endcase
            end
          end
        endcase
      end

      default: d_illegal = 1'b1;
    endcase

    if (d_illegal) begin
      d_aluc   = ALU_ADD;
      d_imm    = '0;
      d_rs1    = '0;
      d_rs2    = '0;
      d_rd     = '0;
      d_a_sel  = 1'b0;
      d_b_sel  = 1'b0;
      d_we     = 1'b0;
      d_mem_rd = 1'b0;
      d_mem_wr = 1'b0;
      d_branch = 1'b0;
      d_jump   = 1'b0;
    end

    // Writes to x0 are dropped here so execute never needs to check rd.
    if (d_rd == 5'd0) begin
      d_we = 1'b0;
    end
  end

  // Output register. Flush has priority over an offered instruction and
  // only clears the valid bit; the payload is don't-care while invalid.
  // With nothing accepted, a consumed bundle simply goes invalid, and an
  // unconsumed one is held untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      aluc      <= '0;
      imm       <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      a_sel     <= 1'b0;
      b_sel     <= 1'b0;
      reg_we    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      funct3_o  <= '0;
      branch    <= 1'b0;
      jump      <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      aluc      <= d_aluc;
      imm       <= d_imm;
      rs1       <= d_rs1;
      rs2       <= d_rs2;
      rd        <= d_rd;
      a_sel     <= d_a_sel;
      b_sel     <= d_b_sel;
      reg_we    <= d_we;
      mem_rd    <= d_mem_rd;
      mem_wr    <= d_mem_wr;
      funct3_o  <= f_funct3;
      branch    <= d_branch;
      jump      <= d_jump;
      illegal   <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_id_decode_stage
//
// Self-checking bench for id_decode_stage. Every stimulus vector carries a
// hand-decoded expected bundle. When the DUT accepts a vector, its expected
// bundle is pushed to a scoreboard queue. A negedge monitor compares every
// valid output against the queue head and pops it on transfer. Flush and
// reset empty the queue, so any bundle that should have died shows up as an
// unexpected output.
// ---------------------------------------------------------------------------
module tb_id_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  aluc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        a_sel;
    logic        b_sel;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [2:0]  f3;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  aluc;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        a_sel;
  logic        b_sel;
  logic        reg_we;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3_o;
  logic        branch;
  logic        jump;
  logic        illegal;

  int   testCount = 0;
  int   failCount = 0;
  exp_t sb[$];
  exp_t curExp;
  exp_t vec[$];
  logic monEn     = 1'b0;
  logic randStall = 1'b0;

  id_decode_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluc      (aluc),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .reg_we    (reg_we),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .funct3_o  (funct3_o),
    .branch    (branch),
    .jump      (jump),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  // Builds an expected bundle; flags = {a_sel,b_sel,reg_we,mem_rd,mem_wr,branch,jump,illegal}.
  function automatic exp_t mk(input logic [31:0] i, input logic [5:0] a,
                              input logic [31:0] im, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] d,
                              input logic [7:0] flags, input logic [2:0] f3);
    exp_t e;
    e.instr   = i;
    e.aluc    = a;
    e.imm     = im;
    e.rs1     = r1;
    e.rs2     = r2;
    e.rd      = d;
    e.a_sel   = flags[7];
    e.b_sel   = flags[6];
    e.reg_we  = flags[5];
    e.mem_rd  = flags[4];
    e.mem_wr  = flags[3];
    e.branch  = flags[2];
    e.jump    = flags[1];
    e.illegal = flags[0];
    e.f3      = f3;
    return e;
  endfunction

  // Offers one instruction and holds it until the DUT takes it. Returns
  // #1 after the accepting edge with in_valid still high.
  task automatic applyStimulus(input exp_t e);
    logic taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    instr    = e.instr;
    pc       = $urandom;
    curExp   = e;
    for (int k = 0; k < 200 && !taken; k++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare, pop on transfer, clear on flush/reset,
  // then push whatever is being accepted at the coming edge.
  always @(negedge clk) begin
    if (monEn) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("aluc[%08h]", sb[0].instr),    32'(aluc),     32'(sb[0].aluc));
          checkOutput($sformatf("imm[%08h]", sb[0].instr),     imm,           sb[0].imm);
          checkOutput($sformatf("rs1[%08h]", sb[0].instr),     32'(rs1),      32'(sb[0].rs1));
          checkOutput($sformatf("rs2[%08h]", sb[0].instr),     32'(rs2),      32'(sb[0].rs2));
          checkOutput($sformatf("rd[%08h]", sb[0].instr),      32'(rd),       32'(sb[0].rd));
          checkOutput($sformatf("a_sel[%08h]", sb[0].instr),   32'(a_sel),    32'(sb[0].a_sel));
          checkOutput($sformatf("b_sel[%08h]", sb[0].instr),   32'(b_sel),    32'(sb[0].b_sel));
          checkOutput($sformatf("reg_we[%08h]", sb[0].instr),  32'(reg_we),   32'(sb[0].reg_we));
          checkOutput($sformatf("mem_rd[%08h]", sb[0].instr),  32'(mem_rd),   32'(sb[0].mem_rd));
          checkOutput($sformatf("mem_wr[%08h]", sb[0].instr),  32'(mem_wr),   32'(sb[0].mem_wr));
          checkOutput($sformatf("branch[%08h]", sb[0].instr),  32'(branch),   32'(sb[0].branch));
          checkOutput($sformatf("jump[%08h]", sb[0].instr),    32'(jump),     32'(sb[0].jump));
          checkOutput($sformatf("illegal[%08h]", sb[0].instr), 32'(illegal),  32'(sb[0].illegal));
          checkOutput($sformatf("funct3[%08h]", sb[0].instr),  32'(funct3_o), 32'(sb[0].f3));
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (rst || flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back(curExp);
      end
    end
  end

  // Random backpressure during the streaming phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randStall) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    exp_t vAdd, vSub, vSrai, vLui, vZero, vAddi, vOri;
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    pc        = '0;

    vAdd  = mk(32'h002081B3, 6'h00, 32'h0,        5'd1, 5'd2, 5'd3,  8'b0010_0000, 3'd0);
    vSub  = mk(32'h402081B3, 6'h08, 32'h0,        5'd1, 5'd2, 5'd3,  8'b0010_0000, 3'd0);
    vSrai = mk(32'h40335293, 6'h1D, 32'h3,        5'd6, 5'd0, 5'd5,  8'b0110_0000, 3'd5);
    vLui  = mk(32'h123450B7, 6'h0C, 32'h12345000, 5'd0, 5'd0, 5'd1,  8'b0110_0000, 3'd5);
    vZero = mk(32'h00000000, 6'h00, 32'h0,        5'd0, 5'd0, 5'd0,  8'b0000_0001, 3'd0);
    vAddi = mk(32'hFFF00093, 6'h00, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1,  8'b0110_0000, 3'd0);
    vOri  = mk(32'h0F016113, 6'h0A, 32'h000000F0, 5'd2, 5'd0, 5'd2,  8'b0110_0000, 3'd6);

    vec.push_back(mk(32'h00812283, 6'h00, 32'h8,        5'd2, 5'd0, 5'd5,  8'b0111_0000, 3'd2)); // LW
    vec.push_back(mk(32'hFE512E23, 6'h00, 32'hFFFFFFFC, 5'd2, 5'd5, 5'd0,  8'b0100_1000, 3'd2)); // SW
    vec.push_back(mk(32'h00208863, 6'h08, 32'h10,       5'd1, 5'd2, 5'd0,  8'b0000_0100, 3'd0)); // BEQ
    vec.push_back(mk(32'hFE20ECE3, 6'h0B, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd0,  8'b0000_0100, 3'd6)); // BLTU
    vec.push_back(mk(32'h001000EF, 6'h00, 32'h800,      5'd0, 5'd0, 5'd1,  8'b1110_0010, 3'd0)); // JAL
    vec.push_back(mk(32'h00008067, 6'h00, 32'h0,        5'd1, 5'd0, 5'd0,  8'b0100_0010, 3'd0)); // JALR x0
    vec.push_back(mk(32'h00001517, 6'h00, 32'h1000,     5'd0, 5'd0, 5'd10, 8'b1110_0000, 3'd1)); // AUIPC
    vec.push_back(mk(32'h0062B233, 6'h0B, 32'h0,        5'd5, 5'd6, 5'd4,  8'b0010_0000, 3'd3)); // SLTU
    vec.push_back(mk(32'h022081B3, 6'h00, 32'h0,        5'd0, 5'd0, 5'd0,  8'b0000_0001, 3'd0)); // MUL
    vec.push_back(mk(32'h009453B3, 6'h0D, 32'h0,        5'd8, 5'd9, 5'd7,  8'b0010_0000, 3'd5)); // SRL
    vec.push_back(mk(32'h40209093, 6'h00, 32'h0,        5'd0, 5'd0, 5'd0,  8'b0000_0001, 3'd1)); // bad SLLI
    vec.push_back(mk(32'h0000B283, 6'h00, 32'h0,        5'd0, 5'd0, 5'd0,  8'b0000_0001, 3'd3)); // LD
    vec.push_back(vOri);
    vec.push_back(mk(32'h00208033, 6'h00, 32'h0,        5'd1, 5'd2, 5'd0,  8'b0000_0000, 3'd0)); // ADD x0
    vec.push_back(vSrai);
    vec.push_back(vAddi);

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    monEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset_aluc",      32'(aluc),      32'd0);
    checkOutput("reset_imm",       imm,            32'd0);
    @(posedge clk);
    #1;

    // Single ADD, one-cycle latency
    applyStimulus(vAdd);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    idle(2);

    // SUB then SRAI back to back at full throughput
    applyStimulus(vSub);
    applyStimulus(vSrai);
    in_valid = 1'b0;
    idle(3);

    // LUI held under backpressure for three cycles
    out_ready = 1'b0;
    applyStimulus(vLui);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready",  32'(in_ready),  32'd0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    idle(2);

    // Flush kills the held bundle and the one offered alongside it
    out_ready = 1'b0;
    applyStimulus(vAddi);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = vSub.instr;
    curExp   = vSub;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    idle(3);

    // All-zero word is illegal
    applyStimulus(vZero);
    in_valid = 1'b0;
    idle(3);

    // Stream the rest under random backpressure
    randStall = 1'b1;
    foreach (vec[i]) applyStimulus(vec[i]);
    in_valid  = 1'b0;
    randStall = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++) idle(1);
    checkOutput("drain_stream", 32'(sb.size()), 32'd0);
    idle(2);

    // Reset while a bundle is held
    out_ready = 1'b0;
    applyStimulus(vOri);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("midrst_aluc",      32'(aluc),      32'd0);
    checkOutput("midrst_imm",       imm,            32'd0);
    checkOutput("midrst_reg_we",    32'(reg_we),    32'd0);
    out_ready = 1'b1;
    idle(3);
    checkOutput("final_queue", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
